prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
// - Boot-time loader upstream of the instruction memory: receives a framed program over a byte stream, writes it word-by-word into IM, then releases the CPU.
// - Holds the single-cycle CPU in reset (cpu_rst_n=0) until a frame has loaded with a good checksum.
// - Frame, all fields little-endian: 2-byte word count N; then N x 4-byte instruction words; then 1-byte checksum = sum mod 256 of all preceding frame bytes.
// PARAMETERS
// - ADDR_W  10    IM word-address width.
// - DEPTH   1024  IM capacity in words; N > DEPTH is a frame error.
// PORTS
// - clk        in   1       Single clock.
// - rst        in   1       Synchronous, active-high reset.
// - start      in   1       1-cycle pulse; re-arms loader from DONE or ERR.
// - in_valid   in   1       Byte-stream valid.
// - in_data    in   8       Byte-stream data.
// - in_ready   out  1       Loader accepts a byte when in_valid & in_ready.
// - im_we      out  1       IM write strobe, 1 cycle per word.
// - im_addr    out  ADDR_W  IM word address.
// - im_wdata   out  32      IM write data.
// - cpu_rst_n  out  1       Active-low CPU reset; 1 only in DONE.
// - done       out  1       Level: frame loaded, checksum OK.
// - err        out  1       Level: frame rejected.
// BEHAVIOUR
// - Reset: state=LEN, in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_rst_n=0, done=0, err=0; byte idx, word count, checksum all cleared.
// - States: LEN -> DATA -> CSUM -> DONE | ERR.
// - LEN: 2 bytes -> N (low byte first); running checksum accumulates both bytes.
//   - After 2nd byte: N==0 -> CSUM; N>DEPTH -> ERR; else -> DATA.
// - DATA: 4-byte shift register assembles word, byte 0 = bits[7:0].
//   - Cycle after 4th byte is accepted: im_we=1 for exactly one cycle, im_wdata=word, im_addr=word index (first word at 0).
//   - im_addr increments after each write.
//   - After word N-1 is written -> CSUM; im_addr holds last written index.
// - CSUM: 1 byte; equal to 8-bit running sum -> DONE, else -> ERR. Checksum byte is not itself summed.
// - DONE: cpu_rst_n=1, done=1, in_ready=0; bytes are ignored.
// - ERR: err=1, cpu_rst_n=0, in_ready=0.
// - start in DONE or ERR: -> LEN next cycle with all counters, im_addr and checksum cleared; done/err/cpu_rst_n drop to 0 in that same cycle.
// - start in LEN/DATA/CSUM: ignored.
// - in_ready is 1 in LEN, DATA, CSUM; the write cycle does not stall input (write is registered; next byte may arrive same cycle).
// - Arithmetic: checksum 8-bit wrap; word counter 16-bit; N compared against DEPTH unsigned.
// - in_valid low: state holds indefinitely; no timeout.
// - rst mid-frame: abandon frame, state LEN, cpu_rst_n=0 next cycle. Partial IM contents are left as written.
// - N==DEPTH is legal; last write goes to im_addr=DEPTH-1 with no wrap.
// STRUCTURE
// - Shared package/include: state encodings (LEN, DATA, CSUM, DONE, ERR), FRAME_HDR_BYTES=2, WORD_BYTES=4.
// - One natural sub-module, byte_packer: 4-byte LE shift register plus 2-bit byte counter emitting word_valid/word. Everything else stays inline.
// TESTING
// - Frame N=2, words 0x20010005 and 0x00000000, correct checksum.
//   - Required: im_we at addr 0 then 1 with those data; done=1; cpu_rst_n=1.
// - Same frame with checksum byte XOR 0x01.
//   - Required: both words written, then err=1, cpu_rst_n=0, done=0.
// - N=0x0401 (DEPTH+1).
//   - Required: err=1 the cycle after the 2nd header byte; im_we never asserted.
// - N=0, checksum byte 0x00.
//   - Required: DONE with no IM writes.
// - in_valid toggled randomly through a 3-word frame.
//   - Required: identical writes and addresses to the back-to-back case; no byte lost or duplicated.
// - rst asserted after byte 5 of a 2-word frame, then the full frame resent.
//   - Required: correct load from addr 0, done=1.
// - DONE, then start, then a new 1-word frame.
//   - Required: cpu_rst_n falls the cycle after start; word written at addr 0; DONE again.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// State encodings and frame geometry.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int FRAME_HDR_BYTES = 2;
    localparam int WORD_BYTES      = 4;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler for the program loader.
// word_valid pulses the cycle after the last byte of a word is pushed.
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] cnt;

    assign last_byte = (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= push && last_byte;
            if (push) begin
                word <= {data, word[31:8]};
                cnt  <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a framed byte stream into IM writes and
// holds the CPU in reset until a frame loads with a good checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    state_t      state;
    logic        hdr_idx;
    logic [7:0]  len_lo;
    logic [15:0] n_words;
    logic [15:0] words_seen;
    logic [7:0]  sum;

    logic        restart;
    logic        accept;
    logic        push;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] len_next;

    assign restart  = start && (state == S_DONE || state == S_ERR);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (state == S_DATA);
    assign len_next = {in_data, len_lo};

    prog_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .push       (push),
        .data       (in_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    assign im_we    = word_valid;
    assign im_wdata = word;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state      <= S_LEN;
            hdr_idx    <= 1'b0;
            len_lo     <= '0;
            n_words    <= '0;
            words_seen <= '0;
            sum        <= '0;
            im_addr    <= '0;
            in_ready   <= 1'b1;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // The last word's write lands after the move to CSUM, so it holds.
            if (word_valid && state == S_DATA)
                im_addr <= im_addr + ADDR_W'(1);
            if (accept) begin
                unique case (state)
                    S_LEN: begin
                        sum <= sum + in_data;
                        if (hdr_idx == 1'(FRAME_HDR_BYTES - 1)) begin
                            hdr_idx <= 1'b0;
                            n_words <= len_next;
                            if (len_next == '0) begin
                                state <= S_CSUM;
                            end else if (32'(len_next) > 32'(DEPTH)) begin
                                state    <= S_ERR;
                                in_ready <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                state <= S_DATA;
                            end
                        end else begin
                            len_lo  <= in_data;
                            hdr_idx <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        sum <= sum + in_data;
                        if (last_byte) begin
                            words_seen <= words_seen + 16'd1;
                            if (words_seen + 16'd1 == n_words)
                                state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        in_ready <= 1'b0;
                        if (in_data == sum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader.
// Expected writes and status come from a frame-parsing reference model.
module tb_prog_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    bit          exp_ok;

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_rst_n (cpu_rst_n),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) begin
            got_a.push_back(32'(im_addr));
            got_d.push_back(im_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    function automatic bq_t make_frame(input wq_t w, input bit bad);
        bq_t f;
        logic [7:0] s;
        logic [15:0] n;
        s = 8'h00;
        n = 16'(w.size());
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        foreach (w[i]) begin
            logic [31:0] v;
            v = w[i];
            for (int b = 0; b < 4; b++) f.push_back(v[8*b +: 8]);
        end
        foreach (f[i]) s = s + f[i];
        f.push_back(bad ? (s ^ 8'h01) : s);
        return f;
    endfunction

    // Reference: parse the frame by its byte-level definition.
    function automatic void model(input bq_t f);
        int n;
        logic [7:0] s;
        logic [31:0] v;
        exp_a.delete();
        exp_d.delete();
        n = int'({f[1], f[0]});
        s = f[0] + f[1];
        if (n > DEPTH) begin
            exp_ok = 1'b0;
            return;
        end
        for (int w = 0; w < n; w++) begin
            v = 32'h0;
            for (int b = 0; b < 4; b++) begin
                v = v | (32'(f[2 + 4*w + b]) << (8*b));
                s = s + f[2 + 4*w + b];
            end
            exp_a.push_back(32'(w));
            exp_d.push_back(v);
        end
        exp_ok = (f[2 + 4*n] == s);
    endfunction

    task automatic send(input bq_t f, input bit gaps);
        int i;
        i = 0;
        while (i < f.size()) begin
            @(negedge clk);
            if (!in_ready) begin
                in_valid = 1'b0;
                break;
            end
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = f[i];
                i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bq_t f, input bit gaps);
        int m;
        got_a.delete();
        got_d.delete();
        model(f);
        send(f, gaps);
        repeat (6) @(negedge clk);
        check({tag, "_nwr"}, 32'(got_a.size()), 32'(exp_a.size()));
        m = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
        end
        check({tag, "_done"}, 32'(done), 32'(exp_ok));
        check({tag, "_err"}, 32'(err), 32'(!exp_ok));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_ok));
        check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t f;
        bq_t hdr;
        bq_t junk;
        wq_t w;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_im_we", 32'(im_we), 32'h0);
        check("rst_im_addr", 32'(im_addr), 32'h0);
        check("rst_im_wdata", im_wdata, 32'h0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        w = '{32'h20010005, 32'h00000000};
        run_frame("good2", make_frame(w, 1'b0), 1'b0);

        do_reset();
        run_frame("badcs", make_frame(w, 1'b1), 1'b0);

        do_reset();
        got_a.delete();
        got_d.delete();
        hdr = '{8'h01, 8'h04};
        send(hdr, 1'b0);
        check("big_err_t1", 32'(err), 32'h1);
        junk = '{8'hAA, 8'h55, 8'h12};
        send(junk, 1'b0);
        repeat (4) @(negedge clk);
        check("big_nwr", 32'(got_a.size()), 32'h0);
        check("big_done", 32'(done), 32'h0);
        check("big_cpu_rst_n", 32'(cpu_rst_n), 32'h0);

        do_reset();
        f = '{8'h00, 8'h00, 8'h00};
        run_frame("n0", f, 1'b0);

        do_reset();
        f = make_frame(rand_words(3), 1'b0);
        run_frame("gap3", f, 1'b1);

        do_reset();
        f = make_frame(rand_words(2), 1'b0);
        send(f[0:4], 1'b0);
        do_reset();
        check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h1);
        run_frame("resend", f, 1'b0);

        check("restart_done_pre", 32'(done), 32'h1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        check("restart_done", 32'(done), 32'h0);
        check("restart_in_ready", 32'(in_ready), 32'h1);
        run_frame("restart1", make_frame(rand_words(1), 1'b0), 1'b0);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            f = make_frame(rand_words($urandom_range(1, 5)),
                           1'($urandom_range(0, 2) == 0));
            run_frame($sformatf("rnd%0d", t), f, 1'($urandom_range(0, 1)));
        end

        do_reset();
        run_frame("full", make_frame(rand_words(DEPTH), 1'b0), 1'b0);
        check("full_last_addr", 32'(im_addr), 32'(DEPTH - 1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
